// File: rtl/audio_playback_ctrl_pkg.sv
// rtl/audio_playback_ctrl_pkg.sv - shared types, constants and volume helper for audio_playback_ctrl
package audio_pkg;

    typedef enum logic [2:0] {IDLE, FETCH, READY, LAST, PAUSE, ABORT} state_t;

    localparam logic [7:0] SILENCE         = 8'h80;
    localparam int         DEFAULT_CLK_DIV = 12500;

    // Attenuate around the unsigned midpoint; an arithmetic shift keeps the sign of the excursion.
    function automatic logic [7:0] apply_volume(input logic [7:0] sample, input logic [2:0] volume);
        logic signed [8:0] diff;
        logic signed [8:0] scaled;
        logic signed [9:0] sum;
        diff   = $signed({1'b0, sample}) - 9'sd128;
        scaled = diff >>> volume;
        sum    = {scaled[8], scaled} + 10'sd128;
        if (sum < 10'sd0) begin
            apply_volume = 8'h00;
        end else if (sum > 10'sd255) begin
            apply_volume = 8'hff;
        end else begin
            apply_volume = sum[7:0];
        end
    endfunction

endpackage

// File: rtl/audio_playback_ctrl_if.sv
// rtl/audio_playback_ctrl_if.sv - sample memory req/ack fetch interface
interface audio_playback_ctrl_if #(
    parameter int ADDR_W = 16
) ();
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [7:0]        mem_data;

    modport master (output mem_req, output mem_addr, input mem_ack, input mem_data);
    modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_data);
endinterface

// File: rtl/audio_playback_ctrl_tick.sv
// rtl/audio_playback_ctrl_tick.sv - sample period counter producing one tick every DIV enabled cycles
module sample_rate_tick #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          at_end;

    assign at_end = (cnt_q == CW'(DIV - 1));
    assign tick   = en && at_end;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = at_end ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/audio_playback_ctrl.sv
// rtl/audio_playback_ctrl.sv - PCM playback sequencer with one-sample prefetch; AUDIO_VOLUME_EN adds volume scaling
module audio_playback_ctrl
    import audio_pkg::*;
#(
    parameter int CLK_DIV = DEFAULT_CLK_DIV,
    parameter int ADDR_W  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_play,
    input  logic                  cmd_pause,
    input  logic                  cmd_stop,
    input  logic                  loop_en,
    input  logic [ADDR_W-1:0]     start_addr,
    input  logic [ADDR_W-1:0]     end_addr,
`ifdef AUDIO_VOLUME_EN
    input  logic [2:0]            volume,
`endif
    audio_playback_ctrl_if.master mem,
    output logic [7:0]            sample_out,
    output logic                  sample_strobe,
    output logic                  busy,
    output logic                  done,
    output logic                  underrun
);
    state_t            state_q, state_d, resume_q, resume_d;
    logic [ADDR_W-1:0] addr_q, addr_d, start_q, start_d, end_q, end_d;
    logic [7:0]        buf_q, buf_d, sample_q, sample_d, next_sample;
    logic              buf_last_q, buf_last_d, strobe_q, strobe_d;
    logic              done_q, done_d, underrun_q, underrun_d;
    logic              req, capture, tick, tick_en, tick_clr;

    // A fetch stays in flight across a pause so the handshake is never abandoned.
    assign req      = (state_q == FETCH) || (state_q == ABORT) ||
                      (state_q == PAUSE && resume_q == FETCH);
    assign capture  = mem.mem_ack && req && (state_q != ABORT);
    assign tick_en  = (state_q == FETCH) || (state_q == READY) || (state_q == LAST);
    assign tick_clr = (state_q == IDLE) || (state_q == ABORT);

`ifdef AUDIO_VOLUME_EN
    assign next_sample = apply_volume(buf_q, volume);
`else
    assign next_sample = buf_q;
`endif

    sample_rate_tick #(.DIV(CLK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .en    (tick_en),
        .clr   (tick_clr),
        .tick  (tick)
    );

    always_comb begin
        state_d    = state_q;
        resume_d   = resume_q;
        addr_d     = addr_q;
        start_d    = start_q;
        end_d      = end_q;
        buf_d      = buf_q;
        buf_last_d = buf_last_q;
        sample_d   = sample_q;
        underrun_d = underrun_q;
        strobe_d   = 1'b0;
        done_d     = 1'b0;

        if (capture) begin
            buf_d      = mem.mem_data;
            buf_last_d = (addr_q == end_q);
            addr_d     = (addr_q == end_q) ? start_q : addr_q + ADDR_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (cmd_play && !cmd_stop) begin
                    start_d    = start_addr;
                    end_d      = end_addr;
                    addr_d     = start_addr;
                    underrun_d = 1'b0;
                    state_d    = FETCH;
                end
            end
            FETCH: begin
                if (cmd_stop) begin
                    sample_d = SILENCE;
                    state_d  = mem.mem_ack ? IDLE : ABORT;
                end else begin
                    if (tick) begin
                        underrun_d = 1'b1;
                    end
                    if (cmd_pause) begin
                        state_d  = PAUSE;
                        resume_d = mem.mem_ack ? READY : FETCH;
                    end else if (mem.mem_ack) begin
                        state_d = READY;
                    end
                end
            end
            READY: begin
                if (cmd_stop) begin
                    sample_d = SILENCE;
                    state_d  = IDLE;
                end else if (cmd_pause) begin
                    state_d  = PAUSE;
                    resume_d = READY;
                end else if (tick) begin
                    sample_d = next_sample;
                    strobe_d = 1'b1;
                    state_d  = (buf_last_q && !loop_en) ? LAST : FETCH;
                end
            end
            LAST: begin
                if (cmd_stop) begin
                    sample_d = SILENCE;
                    state_d  = IDLE;
                end else if (tick) begin
                    sample_d = SILENCE;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end
            end
            PAUSE: begin
                if (cmd_stop) begin
                    sample_d = SILENCE;
                    state_d  = (resume_q == FETCH && !mem.mem_ack) ? ABORT : IDLE;
                end else if (cmd_play) begin
                    state_d = (resume_q == FETCH && mem.mem_ack) ? READY : resume_q;
                end else if (capture) begin
                    resume_d = READY;
                end
            end
            ABORT: begin
                if (mem.mem_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            resume_q   <= FETCH;
            addr_q     <= '0;
            start_q    <= '0;
            end_q      <= '0;
            buf_q      <= SILENCE;
            buf_last_q <= 1'b0;
            sample_q   <= SILENCE;
            strobe_q   <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            resume_q   <= resume_d;
            addr_q     <= addr_d;
            start_q    <= start_d;
            end_q      <= end_d;
            buf_q      <= buf_d;
            buf_last_q <= buf_last_d;
            sample_q   <= sample_d;
            strobe_q   <= strobe_d;
            done_q     <= done_d;
            underrun_q <= underrun_d;
        end
    end

    assign mem.mem_req   = req;
    assign mem.mem_addr  = addr_q;
    assign sample_out    = sample_q;
    assign sample_strobe = strobe_q;
    assign busy          = (state_q != IDLE);
    assign done          = done_q;
    assign underrun      = underrun_q;
endmodule

// File: tb/tb_audio_playback_ctrl.sv
// tb/tb_audio_playback_ctrl.sv - directed self-checking bench for audio_playback_ctrl
module tb_audio_playback_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_play, cmd_pause, cmd_stop, loop_en;
    logic [15:0] start_addr, end_addr;
    logic [7:0]  sample_out;
    logic        sample_strobe, busy, done, underrun;
`ifdef AUDIO_VOLUME_EN
    logic [2:0]  volume;
    localparam logic [7:0] EXP_HI = 8'hA0;
    localparam logic [7:0] EXP_LO = 8'h60;
`else
    localparam logic [7:0] EXP_HI = 8'hC0;
    localparam logic [7:0] EXP_LO = 8'h40;
`endif

    int checks = 0;
    int errors = 0;
    int done_seen = 0;
    int ack_lat = 1;
    int wait_cnt = 0;
    int done_base;
    logic [7:0] mem_img [0:7];

    audio_playback_ctrl_if #(.ADDR_W(16)) mif ();

    audio_playback_ctrl #(.CLK_DIV(4), .ADDR_W(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_play      (cmd_play),
        .cmd_pause     (cmd_pause),
        .cmd_stop      (cmd_stop),
        .loop_en       (loop_en),
        .start_addr    (start_addr),
        .end_addr      (end_addr),
`ifdef AUDIO_VOLUME_EN
        .volume        (volume),
`endif
        .mem           (mif),
        .sample_out    (sample_out),
        .sample_strobe (sample_strobe),
        .busy          (busy),
        .done          (done),
        .underrun      (underrun)
    );

    always #5 clk = ~clk;

    // Memory model: acknowledges after ack_lat cycles of request, away from the active edge.
    always @(negedge clk) begin
        if (reset) begin
            mif.mem_ack  = 1'b0;
            mif.mem_data = 8'h00;
            wait_cnt     = 0;
        end else if (mif.mem_ack) begin
            mif.mem_ack = 1'b0;
            wait_cnt    = 0;
        end else if (mif.mem_req) begin
            if (wait_cnt >= ack_lat) begin
                mif.mem_ack  = 1'b1;
                mif.mem_data = mem_img[mif.mem_addr[2:0]];
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    always @(negedge clk) begin
        if (done === 1'b1) done_seen++;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        mem_img[0] = 8'd10; mem_img[1] = 8'd20; mem_img[2] = 8'd30; mem_img[3] = 8'hC0;
        mem_img[4] = 8'h40; mem_img[5] = 8'h00; mem_img[6] = 8'h00; mem_img[7] = 8'h00;
        reset = 1'b1; cmd_play = 1'b0; cmd_pause = 1'b0; cmd_stop = 1'b0; loop_en = 1'b0;
        start_addr = 16'd0; end_addr = 16'd2;
`ifdef AUDIO_VOLUME_EN
        volume = 3'd0;
`endif
        step(3);
        reset = 1'b0;

        check("rst_sample", 16'(sample_out), 16'h80);
        check("rst_req", 16'(mif.mem_req), 16'h0);
        check("rst_addr", mif.mem_addr, 16'h0);
        check("rst_strobe", 16'(sample_strobe), 16'h0);
        check("rst_busy", 16'(busy), 16'h0);
        check("rst_done", 16'(done), 16'h0);
        check("rst_underrun", 16'(underrun), 16'h0);

        // Clip 0..2, no loop
        cmd_play = 1'b1; step(1); cmd_play = 1'b0;
        check("t1_busy", 16'(busy), 16'h1);
        check("t1_req", 16'(mif.mem_req), 16'h1);
        step(3);
        check("t1_nostrobe3", 16'(sample_strobe), 16'h0);
        step(1);
        check("t1_strobe4", 16'(sample_strobe), 16'h1);
        check("t1_s0", 16'(sample_out), 16'd10);
        step(1);
        check("t1_strobe_pulse", 16'(sample_strobe), 16'h0);
        step(3);
        check("t1_s1", 16'(sample_out), 16'd20);
        step(4);
        check("t1_s2", 16'(sample_out), 16'd30);
        check("t1_strobe12", 16'(sample_strobe), 16'h1);
        step(3);
        check("t1_done_early", 16'(done), 16'h0);
        step(1);
        check("t1_done", 16'(done), 16'h1);
        check("t1_end_silence", 16'(sample_out), 16'h80);
        check("t1_busy_end", 16'(busy), 16'h0);
        step(1);
        check("t1_done_pulse", 16'(done), 16'h0);

        // Looping
        loop_en = 1'b1;
        done_base = done_seen;
        cmd_play = 1'b1; step(1); cmd_play = 1'b0;
        step(4);  check("t2_s0", 16'(sample_out), 16'd10);
        step(4);  check("t2_s1", 16'(sample_out), 16'd20);
        step(4);  check("t2_s2", 16'(sample_out), 16'd30);
        step(4);  check("t2_wrap", 16'(sample_out), 16'd10);
        check("t2_wrap_strobe", 16'(sample_strobe), 16'h1);
        step(4);  check("t2_s4", 16'(sample_out), 16'd20);
        step(2);
        cmd_stop = 1'b1; step(1); cmd_stop = 1'b0;
        check("t2_stop_silence", 16'(sample_out), 16'h80);
        check("t2_stop_busy", 16'(busy), 16'h0);
        check("t2_no_done", 16'(done_seen - done_base), 16'h0);

        // Underrun, then stop with a fetch outstanding
        loop_en = 1'b0;
        cmd_play = 1'b1; step(1); cmd_play = 1'b0;
        check("t3_underrun_clr", 16'(underrun), 16'h0);
        step(4);  check("t3_s0", 16'(sample_out), 16'd10);
        ack_lat = 6;
        step(4);
        check("t3_underrun", 16'(underrun), 16'h1);
        check("t3_missed_strobe", 16'(sample_strobe), 16'h0);
        check("t3_held", 16'(sample_out), 16'd10);
        step(4);
        check("t3_recover", 16'(sample_out), 16'd20);
        check("t3_recover_strobe", 16'(sample_strobe), 16'h1);
        check("t3_sticky", 16'(underrun), 16'h1);
        ack_lat = 1;
        cmd_stop = 1'b1; step(1); cmd_stop = 1'b0;
        check("t5_abort_busy", 16'(busy), 16'h1);
        check("t5_abort_req", 16'(mif.mem_req), 16'h1);
        check("t5_abort_silence", 16'(sample_out), 16'h80);
        step(1);
        check("t5_abort_idle", 16'(busy), 16'h0);
        check("t5_abort_req_drop", 16'(mif.mem_req), 16'h0);

        // Pause with a fetch in flight
        ack_lat = 3;
        cmd_play = 1'b1; step(1); cmd_play = 1'b0;
        check("t4_underrun_clr", 16'(underrun), 16'h0);
        cmd_pause = 1'b1; step(1); cmd_pause = 1'b0;
        step(1);
        check("t4_req_held", 16'(mif.mem_req), 16'h1);
        check("t4_busy", 16'(busy), 16'h1);
        step(2);
        check("t4_req_drop", 16'(mif.mem_req), 16'h0);
        step(2);
        check("t4_no_strobe", 16'(sample_strobe), 16'h0);
        check("t4_paused_silence", 16'(sample_out), 16'h80);
        cmd_play = 1'b1; step(1); cmd_play = 1'b0;
        step(2);
        check("t4_resume_wait", 16'(sample_strobe), 16'h0);
        step(1);
        check("t4_resume_strobe", 16'(sample_strobe), 16'h1);
        check("t4_resume_s0", 16'(sample_out), 16'd10);

        // Stop and play together in READY
        step(4);
        check("t5_ready_req", 16'(mif.mem_req), 16'h0);
        cmd_stop = 1'b1; cmd_play = 1'b1; step(1); cmd_stop = 1'b0; cmd_play = 1'b0;
        check("t5_stop_wins", 16'(busy), 16'h0);
        check("t5_stop_silence", 16'(sample_out), 16'h80);
        step(1);
        check("t5_still_idle", 16'(busy), 16'h0);

        // Volume path (unity when the feature is absent)
        ack_lat = 1;
        start_addr = 16'd3; end_addr = 16'd4;
`ifdef AUDIO_VOLUME_EN
        volume = 3'd1;
`endif
        cmd_play = 1'b1; step(1); cmd_play = 1'b0;
        step(4);  check("t6_hi", 16'(sample_out), 16'(EXP_HI));
        step(4);  check("t6_lo", 16'(sample_out), 16'(EXP_LO));
        step(4);
        check("t6_done", 16'(done), 16'h1);
        check("t6_silence", 16'(sample_out), 16'h80);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/audio_playback_ctrl.md
Name: audio_playback_ctrl

Overview:
Playback sequencer that feeds 8-bit unsigned PCM samples to the PWM audio output stage at a programmable sample rate.
- Fetches samples from a sample memory (BRAM/ROM wrapper) over a req/ack handshake, one sample of prefetch.
- Presents one sample per sample period on sample_out, which connects to the PWM stage's music_data input.
- Handles play, pause, stop, looping, end-of-clip and underrun detection.

Parameters:
CLK_DIV, 12500, clk cycles per sample period (100 MHz / 8 kHz); must be >= 4
ADDR_W, 16, sample memory address width

Ports:
clk  in  1  100 MHz clock
reset  in  1  synchronous, active-high
cmd_play  in  1  single-cycle pulse: start from IDLE, or resume from PAUSE
cmd_pause  in  1  single-cycle pulse: pause playback
cmd_stop  in  1  single-cycle pulse: abort playback
loop_en  in  1  level: wrap end_addr -> start_addr
start_addr  in  ADDR_W  first sample address; sampled on play from IDLE
end_addr  in  ADDR_W  last sample address (inclusive); sampled on play from IDLE
mem_req  out  1  fetch request
mem_addr  out  ADDR_W  fetch address, stable while mem_req=1
mem_ack  in  1  one-cycle acknowledge; mem_data valid in the same cycle
mem_data  in  8  sample data
sample_out  out  8  current sample, to the PWM stage
sample_strobe  out  1  one-cycle pulse each time sample_out updates
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at natural end of clip
underrun  out  1  sticky; cleared on play from IDLE

Behaviour:
- Reset values: sample_out=8'h80 (SILENCE), mem_req=0, mem_addr=0, sample_strobe=0, busy=0, done=0, underrun=0, state=IDLE, tick counter=0.
- Tick counter:
  - Counts 0..CLK_DIV-1 in FETCH, READY and LAST; frozen in PAUSE; held at 0 in IDLE.
  - tick=1 in the cycle the count is CLK_DIV-1.
  - Cleared on play from IDLE, so the first tick occurs CLK_DIV cycles after cmd_play.
- States:
  - IDLE: on cmd_play, latch start_addr/end_addr, addr<=start_addr, clear underrun, go to FETCH.
  - FETCH: mem_req=1 with mem_addr=addr. On mem_ack: buf<=mem_data, buf_last<=(addr==end_addr), advance addr, go to READY. mem_req deasserts in the cycle after ack.
    - Address advance: addr+1 modulo 2^ADDR_W; if addr==end_addr, next addr is start_addr (the value is used only when loop_en=1).
    - Tick while in FETCH: set underrun; sample_out holds its value; no strobe.
  - READY: on tick, sample_out<=buf and sample_strobe=1.
    - buf_last=0, or loop_en=1: go to FETCH.
    - buf_last=1 and loop_en=0: go to LAST.
  - LAST: on the next tick, sample_out<=8'h80, done=1, go to IDLE.
  - PAUSE: sample_out held, no strobes. mem_req stays asserted until ack if a fetch is in flight; the data is captured. cmd_play returns to the saved state (FETCH, or READY if the fetch has completed).
- Handshake rule: mem_req is never dropped before mem_ack, including on stop and pause.
- Stop: from any non-IDLE state, sample_out<=8'h80 next cycle; no done pulse.
  - If no fetch is outstanding, go to IDLE.
  - If a fetch is outstanding, go to ABORT, which holds mem_req until ack, then goes to IDLE (busy=1 while in ABORT).
- Command priority when pulses coincide: stop > pause > play. cmd_play while playing is ignored. cmd_pause in IDLE, LAST or ABORT is ignored.
- mem_ack while mem_req=0 is ignored.
- Reset mid-fetch: immediate return to reset values; the memory side must tolerate a dropped request.

Optional Feature:
AUDIO_VOLUME_EN:
- Defined: adds input port volume[2:0]. Output value is 8'h80 + ((sample-8'h80) >>> volume), signed 9-bit arithmetic, result clipped to 8 bits, registered together with sample_out (no added latency). volume=0 passes the sample unchanged.
- Undefined: no volume port; the sample passes unmodified.

Decomposition:
- Package audio_pkg holds:
  - state enum {IDLE, FETCH, READY, LAST, PAUSE, ABORT}
  - localparam SILENCE=8'h80
  - DEFAULT_CLK_DIV=12500
- Sub-module sample_rate_tick: parameter DIV; inputs en and clr; output tick.

Test Plan:
1. CLK_DIV=4, start=0, end=2, loop_en=0, memory {10,20,30}, ack 1 cycle after req -> strobes at cycles 4, 8, 12 with 10, 20, 30; at cycle 16 sample_out=80h and done=1; busy=0 afterward.
2. Same setup with loop_en=1 -> sequence 10, 20, 30, 10, 20 … with no done pulse; cmd_stop -> sample_out=80h next cycle, IDLE.
3. CLK_DIV=4, ack delayed 6 cycles -> underrun=1, no strobe at the missed tick, previous sample held; underrun still set after recovery.
4. cmd_pause while mem_req is high, ack 3 cycles later -> mem_req held until ack, tick counter frozen, no strobes; cmd_play -> next strobe after the remaining tick count.
5. cmd_stop and cmd_play in the same cycle during READY -> IDLE, sample_out=80h; cmd_stop with a fetch outstanding -> ABORT until ack, then IDLE.
6. AUDIO_VOLUME_EN defined, volume=1, sample C0h -> sample_out=A0h; sample 40h -> 60h.
